fpdiv_ctrl: RTL and testbench
=============================

// Module: fpdiv_ctrl
// PURPOSE
//  Control sequencer directly upstream of the fpdiv Goldschmidt datapath.
//  Accepts a divide request and generates the per-cycle datapath controls
//  (en_a, en_b, en_rem, sel_mux3, sel_mux4, rm), then pulses done.
//  Replaces the hand-timed control stimulus, so fpdiv can be driven
//  back-to-back by a single request/ready handshake.
// PARAMETERS
//  ITERATIONS  5  refinement iterations after the initial-approximation step; legal range 1..15
//  CNT_W       4  iteration counter width; must satisfy 2**CNT_W > ITERATIONS
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-low reset
//  req_valid   in   1   divide request present
//  req_ready   out  1   controller can accept (high only in IDLE)
//  req_rm      in   1   rounding mode, captured on acceptance
//  flush       in   1   synchronous abort of the operation in flight
//  en_a        out  1   load numerator-path register A
//  en_b        out  1   load denominator-path register B
//  en_rem      out  1   load remainder register
//  sel_mux3    out  2   multiplier operand select (00=IA, 01=C reg, 10=rem)
//  sel_mux4    out  2   multiplier source select (00=N, 01=D, 10=A, 11=B)
//  rm          out  1   rounding mode held for the whole operation
//  busy        out  1   operation in flight (any state except IDLE)
//  done        out  1   one-cycle pulse; result at fpdiv output is valid
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, iter_cnt=0, rm=0, done=0,
//    en_a/en_b/en_rem=0, sel_mux3/sel_mux4=00, busy=0, req_ready=1.
//  - All outputs are registered (Moore outputs); no combinational path from input to output.
//  - Accept when req_valid && req_ready && !flush at posedge; rm<=req_rm.
//  - States and outputs (cycles after the accepting edge):
//    IDLE    : all enables 0, sels 00, req_ready=1
//    INIT_N  : sel4=00 sel3=00 en_a=1                 (1 cycle)
//    INIT_D  : sel4=01 sel3=00 en_b=1                 (1 cycle); iter_cnt<=1
//    ITER_N  : sel4=10 sel3=01 en_a=1                 -> ITER_D
//    ITER_D  : sel4=11 sel3=01 en_b=1; if iter_cnt==ITERATIONS -> REM,
//              else iter_cnt++ and -> ITER_N
//    REM     : sel4=10 sel3=10 en_rem=1               -> DONE
//    DONE    : done=1 for exactly one cycle           -> IDLE
//  - Latency from accept to done: 2*ITERATIONS+4 cycles (14 at default).
//    The next request is accepted on the cycle after DONE (IDLE).
//  - Exactly one of en_a/en_b/en_rem is high in every non-IDLE, non-DONE cycle.
//  - flush in any state: next state IDLE with IDLE outputs; no done pulse.
//    flush together with req_valid in IDLE: flush wins, request is not accepted.
//  - Reset mid-operation: same as the reset values; the operation is dropped silently.
//  - req_valid held during busy is ignored; it is not queued.
// CONFIGURATION
//  FPDIV_CTRL_OPLATCH_EN defined:
//    - Adds ports: req_num in 32, req_den in 32, op_num out 32, op_den out 32.
//    - Operands are captured on acceptance and held stable until the next acceptance.
//    - op_num/op_den reset to 0.
//  FPDIV_CTRL_OPLATCH_EN undefined:
//    - The four ports are absent; the requester holds the operands itself.
//  The control sequence and timing are identical in both builds.
// STRUCTURE
//  - fpdiv_pkg holds:
//    - typedef enum logic [2:0] fpdiv_state_t {IDLE, INIT_N, INIT_D, ITER_N, ITER_D, REM, DONE}
//    - localparams SEL3_IA/SEL3_C/SEL3_REM and SEL4_N/SEL4_D/SEL4_A/SEL4_B
//  - Sub-module fpdiv_ctrl_decode: combinational next-state -> control word;
//    its result is registered in fpdiv_ctrl.
// TESTING
//  1 Reset: hold reset=0 for 3 cycles -> req_ready=1, busy=0, all enables/sels=0, done=0.
//  2 Single op (ITERATIONS=5): pulse req_valid with req_rm=1 ->
//    en_a/en_b alternate with sel4 = 00,01,10,11 x5, then en_rem with sel3=10;
//    done is pulsed 14 cycles after accept; rm stays 1 throughout.
//  3 Back-to-back: keep req_valid=1 continuously -> accepts spaced exactly
//    15 cycles apart; req_ready is low for the 14 busy cycles.
//  4 Flush at ITER_D of iteration 3 -> next cycle IDLE, enables 0, no done pulse;
//    a new request is accepted on the following cycle.
//  5 Reset=0 asserted in REM -> next cycle reset values, no done pulse.
//  6 OPLATCH build: req_num=3F800000, req_den=40000000, then change the inputs
//    while busy -> op_num/op_den hold 3F800000/40000000 until done.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// ============================================================================
// fpdiv_pkg
// Shared definitions for the fpdiv control sequencer:
//   - fpdiv_state_t : sequencer state encoding
//   - SEL3_* / SEL4_* : multiplier operand / source select codes
//   - fpdiv_ctrl_t  : one cycle's worth of registered control outputs
//   - CTRL_IDLE     : control word presented while idle (and after reset)
// ============================================================================
package fpdiv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT_N = 3'd1,
        INIT_D = 3'd2,
        ITER_N = 3'd3,
        ITER_D = 3'd4,
        REM    = 3'd5,
        DONE   = 3'd6
    } fpdiv_state_t;

    // Multiplier operand select (mux3)
    localparam logic [1:0] SEL3_IA  = 2'b00;
    localparam logic [1:0] SEL3_C   = 2'b01;
    localparam logic [1:0] SEL3_REM = 2'b10;

    // Multiplier source select (mux4)
    localparam logic [1:0] SEL4_N = 2'b00;
    localparam logic [1:0] SEL4_D = 2'b01;
    localparam logic [1:0] SEL4_A = 2'b10;
    localparam logic [1:0] SEL4_B = 2'b11;

    typedef struct packed {
        logic       en_a;
        logic       en_b;
        logic       en_rem;
        logic [1:0] sel_mux3;
        logic [1:0] sel_mux4;
        logic       done;
        logic       busy;
        logic       req_ready;
    } fpdiv_ctrl_t;

    localparam fpdiv_ctrl_t CTRL_IDLE = '{
        en_a:      1'b0,
        en_b:      1'b0,
        en_rem:    1'b0,
        sel_mux3:  SEL3_IA,
        sel_mux4:  SEL4_N,
        done:      1'b0,
        busy:      1'b0,
        req_ready: 1'b1
    };

endpackage

// File: rtl/fpdiv_ctrl_decode.sv
// ============================================================================
// fpdiv_ctrl_decode
// Purely combinational: maps a sequencer state to the control word the
// datapath needs while the sequencer sits in that state. The top feeds it
// the *next* state and registers the result, so every control output is a
// flop that lines up with the state register.
// Ports:
//   state : fpdiv_state_t  in   state to decode
//   ctrl  : fpdiv_ctrl_t   out  control word for that state
// ============================================================================
module fpdiv_ctrl_decode
    import fpdiv_pkg::*;
(
    input  fpdiv_state_t state,
    output fpdiv_ctrl_t  ctrl
);

    always_comb begin
        // NOTE: default every field first so no path through the case leaves
        // a field unassigned; otherwise synthesis infers a latch.
        ctrl           = CTRL_IDLE;
        ctrl.busy      = 1'b1;
        ctrl.req_ready = 1'b0;

        case (state)
            IDLE: begin
                ctrl = CTRL_IDLE;
            end
            INIT_N: begin
                ctrl.sel_mux4 = SEL4_N;
                ctrl.sel_mux3 = SEL3_IA;
                ctrl.en_a     = 1'b1;
            end
            INIT_D: begin
                ctrl.sel_mux4 = SEL4_D;
                ctrl.sel_mux3 = SEL3_IA;
                ctrl.en_b     = 1'b1;
            end
            ITER_N: begin
                ctrl.sel_mux4 = SEL4_A;
                ctrl.sel_mux3 = SEL3_C;
                ctrl.en_a     = 1'b1;
            end
            ITER_D: begin
                ctrl.sel_mux4 = SEL4_B;
                ctrl.sel_mux3 = SEL3_C;
                ctrl.en_b     = 1'b1;
            end
            REM: begin
                ctrl.sel_mux4 = SEL4_A;
                ctrl.sel_mux3 = SEL3_REM;
                ctrl.en_rem   = 1'b1;
            end
            DONE: begin
                ctrl.done = 1'b1;
            end
            default: begin
                ctrl = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/fpdiv_ctrl.sv
// ============================================================================
// fpdiv_ctrl
// Control sequencer for the fpdiv Goldschmidt datapath. Accepts one divide
// request through a valid/ready handshake, steps the datapath through the
// initial approximation, ITERATIONS refinement pairs and the remainder step,
// then pulses done. All outputs are registered (Moore).
//
// Build option: define FPDIV_CTRL_OPLATCH_EN to add operand capture
// registers (req_num/req_den in, op_num/op_den out). The control sequence
// and timing do not change with this option.
//
// Parameters:
//   ITERATIONS  refinement iterations after the initial step (1..15)
//   CNT_W       iteration counter width, 2**CNT_W > ITERATIONS
// Ports:
//   clk        in   1   clock
//   reset      in   1   synchronous, active-low reset
//   req_valid  in   1   divide request present
//   req_ready  out  1   high only in IDLE
//   req_rm     in   1   rounding mode, captured on acceptance
//   flush      in   1   synchronous abort; returns to IDLE, no done
//   en_a       out  1   load register A
//   en_b       out  1   load register B
//   en_rem     out  1   load remainder register
//   sel_mux3   out  2   multiplier operand select
//   sel_mux4   out  2   multiplier source select
//   rm         out  1   rounding mode of the current operation
//   busy       out  1   any state except IDLE
//   done       out  1   one-cycle completion pulse
//   req_num    in   32  numerator   (FPDIV_CTRL_OPLATCH_EN only)
//   req_den    in   32  denominator (FPDIV_CTRL_OPLATCH_EN only)
//   op_num     out  32  held numerator   (FPDIV_CTRL_OPLATCH_EN only)
//   op_den     out  32  held denominator (FPDIV_CTRL_OPLATCH_EN only)
// ============================================================================
module fpdiv_ctrl
    import fpdiv_pkg::*;
#(
    parameter int ITERATIONS = 5,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rm,
    input  logic        flush,
`ifdef FPDIV_CTRL_OPLATCH_EN
    input  logic [31:0] req_num,
    input  logic [31:0] req_den,
    output logic [31:0] op_num,
    output logic [31:0] op_den,
`endif
    output logic        en_a,
    output logic        en_b,
    output logic        en_rem,
    output logic [1:0]  sel_mux3,
    output logic [1:0]  sel_mux4,
    output logic        rm,
    output logic        busy,
    output logic        done
);

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITERATIONS);

    fpdiv_state_t     state;
    fpdiv_state_t     next_state;
    logic [CNT_W-1:0] iter_cnt;
    logic [CNT_W-1:0] iter_cnt_next;
    fpdiv_ctrl_t      ctrl_next;
    fpdiv_ctrl_t      ctrl_q;
    logic             accept;

    // req_ready is a registered copy of (state == IDLE), so using it here
    // keeps the accept condition off any long combinational path.
    assign accept = req_valid && req_ready && !flush;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state    = state;
        iter_cnt_next = iter_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = INIT_N;
                end
            end
            INIT_N: begin
                next_state = INIT_D;
            end
            INIT_D: begin
                next_state    = ITER_N;
                iter_cnt_next = CNT_W'(1);
            end
            ITER_N: begin
                next_state = ITER_D;
            end
            ITER_D: begin
                if (iter_cnt == ITER_LAST) begin
                    next_state = REM;
                end else begin
                    next_state    = ITER_N;
                    iter_cnt_next = iter_cnt + CNT_W'(1);
                end
            end
            REM: begin
                next_state = DONE;
            end
            DONE: begin
                next_state    = IDLE;
                iter_cnt_next = '0;
            end
            default: begin
                next_state    = IDLE;
                iter_cnt_next = '0;
            end
        endcase

        // Abort overrides everything, including an accept in IDLE.
        if (flush) begin
            next_state    = IDLE;
            iter_cnt_next = '0;
        end
    end

    // Outputs are decoded from next_state and registered, so they change
    // on the same edge as the state they belong to.
    fpdiv_ctrl_decode u_decode (
        .state (next_state),
        .ctrl  (ctrl_next)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            iter_cnt <= '0;
            ctrl_q   <= CTRL_IDLE;
            rm       <= 1'b0;
        end else begin
            state    <= next_state;
            iter_cnt <= iter_cnt_next;
            ctrl_q   <= ctrl_next;
            if (accept) begin
                rm <= req_rm;
            end
        end
    end

`ifdef FPDIV_CTRL_OPLATCH_EN
    // Operands are captured with the request and held until the next one,
    // so the requester is free to change req_num/req_den while busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_num <= '0;
            op_den <= '0;
        end else if (accept) begin
            op_num <= req_num;
            op_den <= req_den;
        end
    end
`endif

    assign en_a      = ctrl_q.en_a;
    assign en_b      = ctrl_q.en_b;
    assign en_rem    = ctrl_q.en_rem;
    assign sel_mux3  = ctrl_q.sel_mux3;
    assign sel_mux4  = ctrl_q.sel_mux4;
    assign done      = ctrl_q.done;
    assign busy      = ctrl_q.busy;
    assign req_ready = ctrl_q.req_ready;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// ============================================================================
// tb_fpdiv_ctrl
// Directed bench for fpdiv_ctrl at ITERATIONS=5. Inputs are driven and
// outputs sampled 1 time unit after each rising edge. Observed outputs are
// packed as {rm, busy, req_ready, done, en_a, en_b, en_rem, sel3, sel4}.
// ============================================================================
module tb_fpdiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_rm;
    logic        flush;
    logic        en_a;
    logic        en_b;
    logic        en_rem;
    logic [1:0]  sel_mux3;
    logic [1:0]  sel_mux4;
    logic        rm;
    logic        busy;
    logic        done;
`ifdef FPDIV_CTRL_OPLATCH_EN
    logic [31:0] req_num;
    logic [31:0] req_den;
    logic [31:0] op_num;
    logic [31:0] op_den;
`endif

    int checks = 0;
    int errors = 0;

    logic [10:0] seq [1:15];

    always #5 clk = ~clk;

    fpdiv_ctrl #(
        .ITERATIONS (5),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rm    (req_rm),
        .flush     (flush),
`ifdef FPDIV_CTRL_OPLATCH_EN
        .req_num   (req_num),
        .req_den   (req_den),
        .op_num    (op_num),
        .op_den    (op_den),
`endif
        .en_a      (en_a),
        .en_b      (en_b),
        .en_rem    (en_rem),
        .sel_mux3  (sel_mux3),
        .sel_mux4  (sel_mux4),
        .rm        (rm),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic rm_e, input logic busy_e,
                                       input logic ready_e, input logic done_e,
                                       input logic ea, input logic eb, input logic er,
                                       input logic [1:0] s3, input logic [1:0] s4);
        return {rm_e, busy_e, ready_e, done_e, ea, eb, er, s3, s4};
    endfunction

    function automatic logic [10:0] obs_word();
        return {rm, busy, req_ready, done, en_a, en_b, en_rem, sel_mux3, sel_mux4};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int ndone;

        // Expected trace after an accept with req_rm=1 (index = cycles after accept)
        seq[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0); // INIT_N
        seq[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1); // INIT_D
        for (int i = 0; i < 5; i++) begin
            seq[3 + 2*i] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd2); // ITER_N
            seq[4 + 2*i] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd3); // ITER_D
        end
        seq[13] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2); // REM
        seq[14] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0); // DONE
        seq[15] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0); // IDLE

        reset     = 1'b0;
        req_valid = 1'b0;
        req_rm    = 1'b0;
        flush     = 1'b0;
`ifdef FPDIV_CTRL_OPLATCH_EN
        req_num   = 32'h0;
        req_den   = 32'h0;
`endif

        // 1: reset held for three cycles
        repeat (3) tick();
        check("reset_state", 32'(obs_word()),
              32'(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0)));
        reset = 1'b1;
        tick();
        check("idle_after_reset", 32'(obs_word()),
              32'(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0)));

        // 2: single operation, req_rm=1, single-cycle request pulse
        req_valid = 1'b1;
        req_rm    = 1'b1;
        tick();
        req_valid = 1'b0;
        req_rm    = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            check($sformatf("single_op_c%0d", k), 32'(obs_word()), 32'(seq[k]));
            if (k < 15) tick();
        end

        // 3: back-to-back with req_valid held high; 14 busy cycles per op
        req_valid = 1'b1;
        req_rm    = 1'b1;
        for (int op = 0; op < 2; op++) begin
            tick();
            n     = 0;
            ndone = 0;
            while (!req_ready && n < 40) begin
                n++;
                if (done) ndone++;
                tick();
            end
            check($sformatf("b2b_busy_cycles_op%0d", op), 32'(n), 32'd14);
            check($sformatf("b2b_done_count_op%0d", op), 32'(ndone), 32'd1);
        end
        req_valid = 1'b0;

        // 4: flush in ITER_D of iteration 3, rounding mode 0 this time
        req_valid = 1'b1;
        req_rm    = 1'b0;
        tick();
        req_valid = 1'b0;
        check("flush_op_init_n", 32'(obs_word()),
              32'(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0)));
        repeat (7) tick();
        check("flush_op_iter_d3", 32'(obs_word()),
              32'(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd3)));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_to_idle", 32'(obs_word()),
              32'(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0)));
        req_valid = 1'b1;
        req_rm    = 1'b1;
        tick();
        check("accept_after_flush", 32'(obs_word()),
              32'(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0)));
        // flush back to IDLE, then flush together with req_valid: flush wins
        flush = 1'b1;
        tick();
        tick();
        check("flush_beats_req", 32'(obs_word()),
              32'(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0)));
        flush     = 1'b0;
        req_valid = 1'b0;

        // 5: reset asserted while in REM
        req_valid = 1'b1;
        req_rm    = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (12) tick();
        check("rem_before_reset", 32'(obs_word()), 32'(seq[13]));
        reset = 1'b0;
        tick();
        check("reset_in_rem", 32'(obs_word()),
              32'(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0)));
        reset = 1'b1;
        tick();
        check("no_done_after_reset", 32'(obs_word()),
              32'(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0)));

`ifdef FPDIV_CTRL_OPLATCH_EN
        // 6: operands captured on acceptance and held while busy
        check("op_num_reset", op_num, 32'h0000_0000);
        req_valid = 1'b1;
        req_num   = 32'h3F80_0000;
        req_den   = 32'h4000_0000;
        tick();
        req_valid = 1'b0;
        req_num   = 32'hDEAD_BEEF;
        req_den   = 32'h1234_5678;
        check("op_num_capture", op_num, 32'h3F80_0000);
        check("op_den_capture", op_den, 32'h4000_0000);
        repeat (13) tick();
        check("oplatch_done", 32'(done), 32'd1);
        check("op_num_hold", op_num, 32'h3F80_0000);
        check("op_den_hold", op_den, 32'h4000_0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
